// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned PRESCALE_MIN = 8;
  localparam int unsigned PRESCALE_MAX = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rx_data_sampler.sv
// Per-bit edge counter and three-sample majority voter around the bit centre.
module rx_data_sampler #(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  advance,
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] mid_edge;
  logic [2:0]            samples;

  assign last_edge = prescale - PRESCALE_W'(1);
  assign mid_edge  = prescale >> 1;
  assign bit_end   = active && (edge_cnt == last_edge);

  // Edge counter: runs from the start-detect cycle, wraps at the bit end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
    end else if (advance && !bit_end) begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end else begin
      edge_cnt <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      samples <= '0;
    end else if (active) begin
      if (edge_cnt == mid_edge - PRESCALE_W'(1)) samples[0] <= rx_in;
      if (edge_cnt == mid_edge)                  samples[1] <= rx_in;
      if (edge_cnt == mid_edge + PRESCALE_W'(1)) samples[2] <= rx_in;
    end
  end

  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect with glitch reject, MSB-first deserializer,
// optional parity and stop check, one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e                state;
  state_e                next_state;
  logic                  start_det_c;
  logic                  shift_en_c;
  logic                  par_chk_c;
  logic                  frame_end_c;
  logic                  active;
  logic                  sampled_bit;
  logic                  bit_end;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]      shift_q;
  logic                  par_fail;
  logic                  exp_par_c;
  logic                  stop_fail_c;
  logic                  last_bit_c;

  assign active      = (state != IDLE);
  assign last_bit_c  = (bit_cnt == BIT_CNT_W'(WIDTH - 1));
  assign exp_par_c   = (^shift_q) ^ (par_typ_q == PAR_ODD);
  assign stop_fail_c = !sampled_bit;

  rx_data_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .advance     (active | start_det_c),
    .active      (active),
    .prescale    (prescale_q),
    .rx_in       (RX_IN),
    .sampled_bit (sampled_bit),
    .bit_end     (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (bit_end) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && last_bit_c) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_det_c = 1'b0;
    shift_en_c  = 1'b0;
    par_chk_c   = 1'b0;
    frame_end_c = 1'b0;
    case (state)
      IDLE:    start_det_c = !RX_IN;
      DATA:    shift_en_c  = bit_end;
      PARITY:  par_chk_c   = bit_end;
      STOP:    frame_end_c = bit_end;
      default: ;
    endcase
  end

  // Frame config latch, deserializer, and registered result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (start_det_c) begin
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        bit_cnt    <= '0;
        par_fail   <= 1'b0;
      end
      if (shift_en_c) begin
        shift_q <= {shift_q[WIDTH-2:0], sampled_bit};
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if (par_chk_c) begin
        par_fail <= (sampled_bit != exp_par_c);
      end
      if (frame_end_c) begin
        if (!par_fail && !stop_fail_c) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shift_q;
        end else begin
          PAR_ERR <= par_fail;
          STP_ERR <= stop_fail_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch, back-to-back and reset sequences.
module tb_uart_rx;

  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [7:0]    P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  uart_rx #(.WIDTH(8), .PRESCALE_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int dv_cyc[$];
  int dv_dat[$];
  int pe_cyc[$];
  int se_cyc[$];

  // Log every high output cycle mid-period, so a wide pulse shows up as extra entries.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (DATA_VALID === 1'b1) begin
        dv_cyc.push_back(cyc);
        dv_dat.push_back(int'(P_DATA));
      end
      if (PAR_ERR === 1'b1) pe_cyc.push_back(cyc);
      if (STP_ERR === 1'b1) se_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    dv_cyc.delete();
    dv_dat.delete();
    pe_cyc.delete();
    se_cyc.delete();
  endtask

  // Drive one frame MSB first; config inputs are scrambled after the detect cycle.
  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] data,
                            input bit pb, input bit sb, input bit idle_after, output int t0);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b0;
    t0       = cyc;
    tick(1);
    PRESCALE = (p == 8) ? 6'd32 : 6'd8;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    tick(p - 1);
    for (int b = 7; b >= 0; b--) begin
      RX_IN = data[b];
      tick(p);
    end
    if (pe) begin
      RX_IN = pb;
      tick(p);
    end
    RX_IN = sb;
    tick(p);
    if (idle_after) RX_IN = 1'b1;
  endtask

  typedef struct {
    int         p;
    bit         par_en;
    bit         par_typ;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
    int         exp_cyc;
    logic [7:0] exp_pdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int t0, t1, tg;
    vec_t v;

    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80,  8'hA5};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 176, 8'h3C};
    vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 176, 8'h3C};
    vecs[3] = '{32, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 352, 8'h3C};
    vecs[4] = '{8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 88,  8'h3C};
    vecs[5] = '{12, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 132, 8'h7E};
    vecs[6] = '{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 320, 8'hFF};

    RST = 1'b1;
    tick(3);
    chk("reset p_data", int'(P_DATA), 0);
    chk("reset data_valid", int'(DATA_VALID), 0);
    chk("reset par_err", int'(PAR_ERR), 0);
    chk("reset stp_err", int'(STP_ERR), 0);
    RST = 1'b0;
    tick(2);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      clear_logs();
      send_frame(v.p, v.par_en, v.par_typ, v.data, v.par_bit, v.stop_bit, 1'b1, t0);
      tick(4);
      chk($sformatf("v%0d dv_count", i), dv_cyc.size(), int'(v.exp_dv));
      chk($sformatf("v%0d pe_count", i), pe_cyc.size(), int'(v.exp_pe));
      chk($sformatf("v%0d se_count", i), se_cyc.size(), int'(v.exp_se));
      if (v.exp_dv)
        chk($sformatf("v%0d dv_cycle", i), (dv_cyc.size() > 0) ? dv_cyc[0] - t0 : -1, v.exp_cyc);
      if (v.exp_pe)
        chk($sformatf("v%0d pe_cycle", i), (pe_cyc.size() > 0) ? pe_cyc[0] - t0 : -1, v.exp_cyc);
      if (v.exp_se)
        chk($sformatf("v%0d se_cycle", i), (se_cyc.size() > 0) ? se_cyc[0] - t0 : -1, v.exp_cyc);
      chk($sformatf("v%0d p_data", i), int'(P_DATA), int'(v.exp_pdata));
    end

    // Three-cycle glitch, then a real frame starting exactly in the return-to-IDLE cycle.
    clear_logs();
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    RX_IN    = 1'b0;
    tg       = cyc;
    tick(3);
    RX_IN = 1'b1;
    tick(5);
    chk("glitch no pulses", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, t0);
    tick(4);
    chk("glitch dv_count", dv_cyc.size(), 1);
    chk("glitch dv_cycle", (dv_cyc.size() > 0) ? dv_cyc[0] - tg : -1, 88);
    chk("glitch p_data", int'(P_DATA), 8'h81);
    chk("glitch err_count", pe_cyc.size() + se_cyc.size(), 0);

    // Back-to-back frames with the second start in the first frame's pulse cycle.
    clear_logs();
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, t0);
    send_frame(8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, t1);
    tick(4);
    chk("b2b dv_count", dv_cyc.size(), 2);
    chk("b2b dv0_cycle", (dv_cyc.size() > 0) ? dv_cyc[0] - t0 : -1, 80);
    chk("b2b dv1_cycle", (dv_cyc.size() > 1) ? dv_cyc[1] - t0 : -1, 160);
    chk("b2b dv0_data", (dv_dat.size() > 0) ? dv_dat[0] : -1, 8'h55);
    chk("b2b dv1_data", (dv_dat.size() > 1) ? dv_dat[1] : -1, 8'hAA);
    chk("b2b err_count", pe_cyc.size() + se_cyc.size(), 0);

    // Reset while in DATA, then a clean frame.
    clear_logs();
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(8);
    RX_IN = 1'b0;
    tick(8);
    RST   = 1'b1;
    RX_IN = 1'b1;
    tick(2);
    chk("midrst p_data", int'(P_DATA), 0);
    chk("midrst data_valid", int'(DATA_VALID), 0);
    chk("midrst par_err", int'(PAR_ERR), 0);
    chk("midrst stp_err", int'(STP_ERR), 0);
    RST = 1'b0;
    tick(100);
    chk("midrst no pulses", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
    send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, t0);
    tick(4);
    chk("midrst dv_count", dv_cyc.size(), 1);
    chk("midrst dv_cycle", (dv_cyc.size() > 0) ? dv_cyc[0] - t0 : -1, 80);
    chk("midrst p_data after", int'(P_DATA), 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART core for the UART block. It oversamples the serial line RX_IN by PRESCALE clocks per bit and detects a start bit, rejecting glitches. It majority-samples and deserializes WIDTH data bits, with the first received bit landing in P_DATA[WIDTH-1]; this matches the transmit serializer, which sends MSB first. It then checks optional parity and the stop bit, and presents the byte on P_DATA with a one-cycle DATA_VALID pulse toward the system controller or synchronizer.

## Interface
- WIDTH, 8, data bits per frame
- PRESCALE_W, 6, width of the PRESCALE input
- CLK  input  1  receiver oversampling clock; all logic on its rising edge
- RST  input  1  synchronous, active-high reset
- RX_IN  input  1  serial line, idle high; already synchronized to CLK upstream
- PRESCALE  input  PRESCALE_W  clocks per bit; must be even, range 8..32
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  WIDTH  last good received word
- DATA_VALID  output  1  one-cycle pulse: P_DATA updated with a good frame
- PAR_ERR  output  1  one-cycle pulse: parity mismatch in the frame just ended
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0

## Operation
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..P-1 within each bit. bit_cnt counts data bits 0..WIDTH-1.
- Sampling:
  - RX_IN is registered at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the three samples, valid at edge_cnt = P-1.
  - All state decisions are made at edge_cnt = P-1.
- Frame start:
  - In IDLE, the first cycle with RX_IN=0 is edge 0 of the start bit. The next cycle is in START with edge_cnt=1.
  - PRESCALE, PAR_EN and PAR_TYP are latched in that detect cycle and held for the whole frame. Mid-frame changes are ignored.
- START: a majority value of 1 means a glitch; return to IDLE with no error pulse. A value of 0 goes to DATA.
- DATA:
  - At each bit end, the shift register shifts left with the sampled bit entering the LSB.
  - After WIDTH bits the state goes to PARITY if PAR_EN, else STOP.
- PARITY: the expected bit is (^data) ^ PAR_TYP. A mismatch sets an internal par_fail flag. The state then goes to STOP.
- STOP, at edge_cnt = P-1:
  - stop_fail = (majority == 0).
  - Next cycle, the FSM is in IDLE, and in that same cycle:
    - If neither par_fail nor stop_fail is set: DATA_VALID=1 and P_DATA equals the shifted word.
    - Otherwise: PAR_ERR=par_fail and STP_ERR=stop_fail (both may be 1). DATA_VALID stays 0 and P_DATA keeps its old value.
- P_DATA changes only on a good frame.
- A line held low (break) re-detects a start in the first IDLE cycle. Each such frame ends with STP_ERR; no DATA_VALID is produced.
- Reset: state=IDLE, counters=0, shift register=0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. Reset mid-frame abandons the frame with no pulses. The receiver needs RX_IN=0 after reset to start a frame.

## Timing
- Let cycle 0 be the IDLE cycle where RX_IN is first seen 0, and N = WIDTH + 2 + PAR_EN.
- DATA_VALID (or the error pulses) assert in cycle N*P.
  - Example: 8N1 at P=8 gives cycle 80. 8E1 at P=16 gives cycle 176.
- Every output pulse is exactly 1 cycle wide. Pulses occur at most once per frame.
- Back-to-back frames: a start edge in the pulse cycle itself is detected. That cycle is cycle 0 of the next frame, so there is no dead cycle.
- A glitch rejected in START returns to IDLE in cycle P. A new start can be detected in cycle P.

## Structure
- Package uart_pkg holds:
  - the state encoding enum (IDLE, START, DATA, PARITY, STOP);
  - the PRESCALE limits, PRESCALE_MIN=8 and PRESCALE_MAX=32;
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module, rx_data_sampler, contains the edge counter and the three-sample majority voter. It outputs sampled_bit and bit_end to the uart_rx FSM and deserializer.

## Test plan
- 8N1, P=8, send 0xA5 MSB-first -> DATA_VALID at cycle 80, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- 8E1, P=16, send 0x3C with correct parity bit 0, then 0x3C with parity bit 1 -> first frame gives DATA_VALID with 0x3C at cycle 176; second gives PAR_ERR at cycle 176, no DATA_VALID, P_DATA stays 0x3C.
- 8O1, P=32, stop bit driven 0 and correct parity -> STP_ERR alone at cycle 352, P_DATA unchanged.
- Glitch: RX_IN low for 3 cycles at P=8 -> returns to IDLE, no pulses. A following valid 0x81 frame is received with DATA_VALID at cycle 80 from its start.
- Back-to-back 0x55 then 0xAA, P=8, no idle gap -> two DATA_VALID pulses at cycles 80 and 160.
- Assert RST during DATA of a frame, then send 0x0F -> no pulse from the aborted frame, all outputs 0, then DATA_VALID with P_DATA=0x0F.
